// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the load/store MEM stage.
//   memop_t  - memory operation encoding carried from EX/MEM
//   state_t  - bus access FSM states (IDLE, WAIT, DONE)
//   is_load / is_store / op_misaligned - operation classification helpers
package mem_pkg;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        LB  = 4'd1,
        LBU = 4'd2,
        LH  = 4'd3,
        LHU = 4'd4,
        LW  = 4'd5,
        SB  = 4'd6,
        SH  = 4'd7,
        SW  = 4'd8
    } memop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LANES = 4;

    function automatic logic is_load(input memop_t op);
        return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) || (op == LW);
    endfunction

    function automatic logic is_store(input memop_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // Halfword accesses need a[0]=0, word accesses need a[1:0]=0.
    function automatic logic op_misaligned(input memop_t op, input logic [1:0] a);
        logic half_op;
        logic word_op;
        half_op = (op == LH) || (op == LHU) || (op == SH);
        word_op = (op == LW) || (op == SW);
        return (half_op && a[0]) || (word_op && (a != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: combinational byte-lane formatter for a 32-bit little-endian bus.
//   op          - memory operation
//   a           - low address bits (byte offset within the word)
//   store_data  - register value to store
//   load_raw    - raw word returned by the bus
//   sel         - byte lane selects for the access
//   store_lanes - store data replicated into every lane of its width
//   load_data   - selected lane(s), sign- or zero-extended to 32 bits
module mem_lane_fmt
    import mem_pkg::*;
(
    input  memop_t      op,
    input  logic [1:0]  a,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  sel,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data
);

    logic [7:0]  lane_byte [LANES];
    logic [31:0] byte_rep;
    logic [31:0] half_rep;
    logic [7:0]  pick_b;
    logic [15:0] pick_h;

    // Lane gi carries bits [8gi+7:8gi]; halfword replication alternates low/high byte.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_byte[gi]       = load_raw[8*gi +: 8];
        assign byte_rep[8*gi +: 8] = store_data[7:0];
        assign half_rep[8*gi +: 8] = store_data[8*(gi%2) +: 8];
    end

    assign pick_b = lane_byte[a];
    assign pick_h = a[1] ? load_raw[31:16] : load_raw[15:0];

    always_comb begin
        sel         = 4'b0000;
        store_lanes = 32'h0;
        load_data   = 32'h0;
        case (op)
            LB:  begin sel = 4'b0001 << a;             load_data = {{24{pick_b[7]}}, pick_b};  end
            LBU: begin sel = 4'b0001 << a;             load_data = {24'h0, pick_b};            end
            LH:  begin sel = a[1] ? 4'b1100 : 4'b0011; load_data = {{16{pick_h[15]}}, pick_h}; end
            LHU: begin sel = a[1] ? 4'b1100 : 4'b0011; load_data = {16'h0, pick_h};            end
            LW:  begin sel = 4'b1111;                  load_data = load_raw;                   end
            SB:  begin sel = 4'b0001 << a;             store_lanes = byte_rep;                 end
            SH:  begin sel = a[1] ? 4'b1100 : 4'b0011; store_lanes = half_rep;                 end
            SW:  begin sel = 4'b1111;                  store_lanes = store_data;               end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_ls_stage.sv
// mem_ls_stage: MEM pipeline stage with load/store over a req/ack data bus.
//   Non-memory ops pass wd/wreg/wdata straight through with zero latency.
//   Loads/stores raise mem_ce_o and stall_req_o in the issue cycle, wait for
//   mem_ack_i (up to MAX_WAIT cycles, else bus_err_o), then present the result
//   for one DONE cycle.
// Ports:
//   clk, rst (sync, active-low)            - clock and reset
//   wd_i, wreg_i, wdata_i, memop_i,
//   mem_addr_i, store_data_i               - from EX/MEM
//   mem_addr_o, mem_we_o, mem_sel_o,
//   mem_data_o, mem_ce_o, mem_data_i,
//   mem_ack_i                              - data bus
//   wd_o, wreg_o, wdata_o                  - to MEM/WB
//   stall_req_o, bus_err_o                 - pipeline control / error pulse
//   align_exc_o                            - only when MEM_ALIGN_EXC_EN is defined
// Build option: define MEM_ALIGN_EXC_EN to trap misaligned halfword/word accesses.
module mem_ls_stage
    import mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  memop_t                memop_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     store_data_i,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic                  mem_we_o,
    output logic [DATA_W/8-1:0]   mem_sel_o,
    output logic [DATA_W-1:0]     mem_data_o,
    output logic                  mem_ce_o,
    input  logic [DATA_W-1:0]     mem_data_i,
    input  logic                  mem_ack_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic                  stall_req_o,
`ifdef MEM_ALIGN_EXC_EN
    output logic                  align_exc_o,
`endif
    output logic                  bus_err_o
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [REG_ADDR_W-1:0] wd_reg;
    logic                  wreg_reg;
    logic [DATA_W-1:0]     wdata_reg;
    memop_t                op_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic [DATA_W-1:0]     sdata_reg;
    logic [DATA_W-1:0]     rdata_reg;

    logic                  latch_en, cap_en, bus_active, use_latched, exc;
    memop_t                fmt_op;
    logic [ADDR_W-1:0]     fmt_addr;
    logic [DATA_W-1:0]     fmt_sdata;
    logic [3:0]            fmt_sel;
    logic [DATA_W-1:0]     fmt_store, fmt_load;

    // Issue cycle drives the bus from the live inputs; afterwards from the latches,
    // so the bus stays stable while the pipeline upstream is stalled.
    assign use_latched = (state_reg != IDLE);
    assign fmt_op      = use_latched ? op_reg    : memop_i;
    assign fmt_addr    = use_latched ? addr_reg  : mem_addr_i;
    assign fmt_sdata   = use_latched ? sdata_reg : store_data_i;

    mem_lane_fmt u_fmt (
        .op          (fmt_op),
        .a           (fmt_addr[1:0]),
        .store_data  (fmt_sdata),
        .load_raw    (rdata_reg),
        .sel         (fmt_sel),
        .store_lanes (fmt_store),
        .load_data   (fmt_load)
    );

    assign mem_ce_o   = bus_active;
    assign mem_we_o   = bus_active & is_store(fmt_op);
    assign mem_addr_o = bus_active ? {fmt_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_sel_o  = bus_active ? fmt_sel : '0;
    assign mem_data_o = bus_active ? fmt_store : '0;

    // Everything is gated by rst so all outputs read 0 while reset is held.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        latch_en    = 1'b0;
        cap_en      = 1'b0;
        bus_active  = 1'b0;
        stall_req_o = 1'b0;
        bus_err_o   = 1'b0;
        wd_o        = '0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        exc         = 1'b0;
`ifdef MEM_ALIGN_EXC_EN
        exc         = rst && (state_reg == IDLE) && op_misaligned(memop_i, mem_addr_i[1:0]);
        align_exc_o = exc;
`endif
        if (rst) begin
            case (state_reg)
                IDLE: begin
                    if (is_load(memop_i) || is_store(memop_i)) begin
                        if (!exc) begin
                            bus_active  = 1'b1;
                            stall_req_o = 1'b1;
                            latch_en    = 1'b1;
                            state_next  = WAIT;
                        end
                    end else begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end
                end
                WAIT: begin
                    bus_active = 1'b1;
                    // cnt_reg counts earlier WAIT cycles; ack is checked first so it wins a tie.
                    if (mem_ack_i) begin
                        cap_en      = 1'b1;
                        stall_req_o = 1'b1;
                        cnt_next    = '0;
                        state_next  = DONE;
                    end else if (cnt_reg == CNT_W'(MAX_WAIT - 1)) begin
                        bus_err_o  = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        stall_req_o = 1'b1;
                        if (cnt_reg < CNT_W'(MAX_WAIT))
                            cnt_next = cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    wd_o       = wd_reg;
                    wreg_o     = is_load(op_reg) & wreg_reg;
                    wdata_o    = is_load(op_reg) ? fmt_load : wdata_reg;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            wd_reg    <= '0;
            wreg_reg  <= 1'b0;
            wdata_reg <= '0;
            op_reg    <= NOP;
            addr_reg  <= '0;
            sdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (latch_en) begin
                wd_reg    <= wd_i;
                wreg_reg  <= wreg_i;
                wdata_reg <= wdata_i;
                op_reg    <= memop_i;
                addr_reg  <= mem_addr_i;
                sdata_reg <= store_data_i;
            end
            if (cap_en)
                rdata_reg <= mem_data_i;
        end
    end

endmodule
